gpio_mulpop: RTL and testbench
==============================

Name: gpio_mulpop

Overview:
Memory-mapped multiply/popcount peripheral on the emulated GPIO bus, with operand width set by a parameter.
- Computes the unsigned product of two ARG_W-bit operands with a sequential shift-add datapath (one multiplier bit per clk).
- Then counts the ones in the full product, publishes both results atomically and keeps an operation counter on gpio_out.
- Also latches gpio_in for bus readback.
- All bus access is synchronous to clk; there are no strobe-edge-clocked processes.

Parameters:
- ARG_W, 24, operand width; legal range 17..32; product width P_W = 2*ARG_W.
- BASE_ADDR, 16'h0380, bus address of register offset 0x00.
- CNT_W, 16, operation counter width (1..32).

Ports:
- clk  input  1  system clock
- n_reset  input  1  asynchronous, active-low reset
- saddress  input  16  bus address
- srd  input  1  read strobe, synchronous to clk
- swr  input  1  write strobe, synchronous to clk
- sdata_in  input  32  write data
- sdata_out  output  32  registered read data
- gpio_in  input  32  external inputs
- gpio_latch  input  1  capture enable for gpio_in
- gpio_out  output  32  zero-extended operation counter
- gpio_in_s_insp  output  32  latched gpio_in, for inspection
- irq  output  1  completion interrupt; tied 0 unless MULPOP_IRQ_EN

Behaviour:
- Reset: asynchronous on n_reset low. All registers, outputs, counters and flags go to 0; FSM goes to IDLE. A reset mid-operation aborts the operation with no result update.
- Strobe detection: srd_q and swr_q are registered copies of srd and swr. A read fires on srd & ~srd_q; a write fires on swr & ~swr_q.
  - Exactly one access per strobe assertion, regardless of how many cycles the strobe is held.
  - Read data is registered: sdata_out is valid after the same edge that detects the read.
- Register map (offset from BASE_ADDR; any other address reads 0 and ignores writes):
  - 0x00 ARG1, RW, [ARG_W-1:0]
  - 0x08 ARG2, RW, [ARG_W-1:0]
  - 0x10 CTRL. Write bit0=1 means start. Read returns status {28'b0, err, valid, done, busy}.
  - 0x18 RESLO, R, product[31:0]
  - 0x20 RESHI, R, product[P_W-1:32], zero-extended
  - 0x28 ONES, R, popcount of the full product
  - 0x30 OPCNT, R, zero-extended opcnt
  - 0x38 GPIN, R, gpio_in_s
- ARG writes are always accepted. A running operation uses working copies taken in LOAD, so ARG writes during an operation do not affect it.
- FSM states: IDLE, LOAD, MULT, COUNT, DONE.
  - IDLE: a start write moves to LOAD at that edge. Same edge: busy=1, done=0, err=0.
  - LOAD: copy ARG1 to mcand (P_W wide) and ARG2 to mplier; clear accumulator and bit counter; go to MULT.
  - MULT: runs ARG_W cycles. Each cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1. Go to COUNT after cycle ARG_W.
  - COUNT: compute the ones count of acc[P_W-1:0] in one cycle; go to DONE.
  - DONE: do all of the following at once, then go to IDLE.
    - Copy acc and ones into the RES registers.
    - valid = (acc[P_W-1:32]==0).
    - done=1, busy=0.
    - opcnt += 1, wrapping from all-ones to 0.
- Latency: done reads 1 after edge E+ARG_W+3, where E is the start edge (27 cycles at ARG_W=24).
- Result registers hold the previous result until DONE, so a read during busy returns the old value.
- Start while busy: ignored, err=1 (sticky until the next accepted start), running operation unaffected.
- Start and another register write in the same cycle: impossible (single address). A start write with bit0=0 has no effect.
- Read and write of the same register in one cycle: the read returns the pre-write value.
- gpio_in_s <= gpio_in on every clk with gpio_latch=1; otherwise it holds. gpio_in_s_insp = gpio_in_s.
- gpio_out = {(32-CNT_W)'b0, opcnt}.

Optional Feature:
MULPOP_IRQ_EN.
- Defined: irq is a register.
  - Set to 1 on entry to DONE.
  - Cleared by a read of CTRL or by an accepted start.
  - If set and clear occur in the same cycle, set wins.
  - Status bit4 mirrors irq.
- Undefined: irq is constant 0 and status bit4 reads 0.

Test Plan:
1. ARG_W=24: ARG1=3, ARG2=5, start -> busy for 27 cycles; then RESLO=15, RESHI=0, ONES=4, status=0b0110, OPCNT=1, gpio_out=1.
2. ARG1=ARG2=0xFFFFFF -> RESLO=0xFE000001, RESHI=0xFFFF, ONES=24, valid=0.
3. Start, then start again 5 cycles later, and write ARG1=7 mid-run -> err=1; result matches the original operands; OPCNT increments only by 1.
4. n_reset low at MULT cycle 10 -> all registers 0, sdata_out=0, gpio_out=0; a new op after release completes normally.
5. Preload opcnt to 0xFFFF via 65535 operations (or force) and run one more -> gpio_out=0. Separately, gpio_latch pulse with gpio_in=0xA5A5A5A5 -> GPIN reads 0xA5A5A5A5 and holds after gpio_in changes.
6. MULPOP_IRQ_EN defined: irq rises with done and falls after a CTRL read; with the macro undefined, irq stays 0 throughout.

Source files
------------

// File: rtl/gpio_mulpop.sv
// gpio_mulpop: bus-mapped ARG_W x ARG_W shift-add multiplier with product popcount, op counter on gpio_out, gpio_in latch.
// Define MULPOP_IRQ_EN to build the completion interrupt (irq output and status bit4); otherwise irq is tied 0.
module gpio_mulpop #(
  parameter int          ARG_W     = 24,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp,
  output logic        irq
);
  localparam int P_W    = 2 * ARG_W;
  localparam int ONES_W = 7;
  localparam logic [5:0] BIT_LAST = 6'(ARG_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, MULT, COUNT, DONE} state_t;
  state_t state, state_next;

  logic              srd_q, swr_q, rd_fire, wr_fire;
  logic [15:0]       offset;
  logic [ARG_W-1:0]  arg1, arg2, mplier;
  logic [P_W-1:0]    mcand, acc, res;
  logic [5:0]        bit_cnt;
  logic [ONES_W-1:0] ones, ones_comb, res_ones;
  logic              busy, done, valid, err;
  logic [CNT_W-1:0]  opcnt;
  logic [31:0]       gpio_in_s, rd_data, status;
  logic [63:0]       res_ext;
  logic              start_req, start_ok, ctrl_rd;
  logic              unused_bits;

  assign rd_fire   = srd & ~srd_q;
  assign wr_fire   = swr & ~swr_q;
  assign offset    = saddress - BASE_ADDR;
  assign start_req = wr_fire && offset == 16'h0010 && sdata_in[0];
  assign start_ok  = start_req && state == IDLE;
  assign ctrl_rd   = rd_fire && offset == 16'h0010;
  assign res_ext   = 64'(res);
  assign status    = {27'b0, irq, err, valid, done, busy};
  assign gpio_out  = 32'(opcnt);
  assign gpio_in_s_insp = gpio_in_s;
  assign unused_bits = ^sdata_in;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    state_next = MULT;
      MULT:    if (bit_cnt == BIT_LAST) state_next = COUNT;
      COUNT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ones_comb = '0;
    for (int i = 0; i < P_W; i++) ones_comb = ones_comb + ONES_W'(acc[i]);
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      16'h0000: rd_data = 32'(arg1);
      16'h0008: rd_data = 32'(arg2);
      16'h0010: rd_data = status;
      16'h0018: rd_data = res_ext[31:0];
      16'h0020: rd_data = res_ext[63:32];
      16'h0028: rd_data = 32'(res_ones);
      16'h0030: rd_data = 32'(opcnt);
      16'h0038: rd_data = gpio_in_s;
      default:  rd_data = '0;
    endcase
  end

  // Bus side: registered reads see the pre-write value of a same-cycle write.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_q     <= 1'b0;
      swr_q     <= 1'b0;
      sdata_out <= '0;
      arg1      <= '0;
      arg2      <= '0;
      gpio_in_s <= '0;
    end else begin
      srd_q <= srd;
      swr_q <= swr;
      if (rd_fire) sdata_out <= rd_data;
      if (wr_fire && offset == 16'h0000) arg1 <= sdata_in[ARG_W-1:0];
      if (wr_fire && offset == 16'h0008) arg2 <= sdata_in[ARG_W-1:0];
      if (gpio_latch) gpio_in_s <= gpio_in;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      bit_cnt  <= '0;
      ones     <= '0;
      res      <= '0;
      res_ones <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      err      <= 1'b0;
      opcnt    <= '0;
    end else begin
      if (start_ok) begin
        busy <= 1'b1;
        done <= 1'b0;
        err  <= 1'b0;
      end else if (start_req) begin
        err <= 1'b1;
      end
      case (state)
        LOAD: begin
          mcand   <= P_W'(arg1);
          mplier  <= arg2;
          acc     <= '0;
          bit_cnt <= '0;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 6'd1;
        end
        COUNT: ones <= ones_comb;
        DONE: begin
          res      <= acc;
          res_ones <= ones;
          valid    <= (acc[P_W-1:32] == '0);
          done     <= 1'b1;
          busy     <= 1'b0;
          opcnt    <= opcnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MULPOP_IRQ_EN
  logic irq_q;
  // Set on the edge entering DONE; a simultaneous clear loses.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                irq_q <= 1'b0;
    else if (state == COUNT)     irq_q <= 1'b1;
    else if (ctrl_rd | start_ok) irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_mulpop.sv
// Self-checking bench for gpio_mulpop: scoreboard of expected products pushed at start, popped at completion.
`timescale 1ns/1ps
module tb_gpio_mulpop;
  localparam int          ARG_W = 24;
  localparam logic [15:0] BASE  = 16'h0380;
`ifdef MULPOP_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0, n_reset = 1'b0, srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
  logic [15:0] saddress = '0;
  logic [31:0] sdata_in = '0, gpio_in = '0;
  logic [31:0] sdata_out, gpio_out, gpio_in_s_insp;
  logic        irq;

  gpio_mulpop #(.ARG_W(ARG_W), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in), .gpio_latch(gpio_latch),
    .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] prod; logic [31:0] ones; logic valid; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0, lat;
  logic [15:0] opcnt_m = '0;
  logic        irq_m = 1'b0;
  logic [31:0] lo, hi, on, st, cnt, d;
  logic [63:0] prev_prod;

  task automatic bus_write(input logic [7:0] off, input logic [31:0] v, input int hold);
    @(negedge clk); saddress = BASE + 16'(off); sdata_in = v; swr = 1'b1;
    repeat (hold) @(negedge clk);
    swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] v);
    @(negedge clk); saddress = BASE + 16'(off); srd = 1'b1;
    @(negedge clk); v = sdata_out; srd = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t x;
    bus_write(8'h00, a, 1);
    bus_write(8'h08, b, 1);
    x.prod  = 64'(a[ARG_W-1:0]) * 64'(b[ARG_W-1:0]);
    x.ones  = $countones(x.prod);
    x.valid = (x.prod[63:32] == 32'd0);
    sb.push_back(x);
    bus_write(8'h10, 32'd1, hold);
  endtask

  // lat counts clock edges after the start edge until gpio_out moves.
  task automatic wait_done(input int already, output int l);
    logic [31:0] g0;
    g0 = gpio_out;
    l = already;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1; l++;
      if (gpio_out !== g0) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL done_timeout: no completion after %0d cycles, required %0d", l, ARG_W + 3);
  endtask

  task automatic read_results(output logic [31:0] rlo, rhi, ron, rst, rcnt);
    bus_read(8'h18, rlo);
    bus_read(8'h20, rhi);
    bus_read(8'h28, ron);
    bus_read(8'h10, rst);
    bus_read(8'h30, rcnt);
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      n_cmp++; n_bad++; $display("FAIL scoreboard: got empty queue, required an entry");
      e.prod = '0; e.ones = '0; e.valid = 1'b0;
    end else e = sb.pop_front();
    opcnt_m++;
    irq_m = IRQ_ON;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (sdata_out !== 32'd0) begin n_bad++; $display("FAIL rst_sdata_out: got %h want 0", sdata_out); end
    n_cmp++; if (gpio_out !== 32'd0) begin n_bad++; $display("FAIL rst_gpio_out: got %h want 0", gpio_out); end
    n_cmp++; if (gpio_in_s_insp !== 32'd0) begin n_bad++; $display("FAIL rst_insp: got %h want 0", gpio_in_s_insp); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_reset = 1'b1;
    bus_read(8'h10, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_status: got %h want 0", d); end
  endtask

  task automatic test_basic();
    launch(32'd3, 32'd5, 3);
    wait_done(3, lat);
    n_cmp++; if (lat !== ARG_W + 3) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, ARG_W + 3); end
    pop_exp();
    n_cmp++; if (irq !== irq_m) begin n_bad++; $display("FAIL basic_irq_set: got %b want %b", irq, irq_m); end
    read_results(lo, hi, on, st, cnt);
    n_cmp++; if ({hi, lo} !== e.prod) begin n_bad++; $display("FAIL basic_product: got %h want %h", {hi, lo}, e.prod); end
    n_cmp++; if (on !== e.ones) begin n_bad++; $display("FAIL basic_ones: got %0d want %0d", on, e.ones); end
    n_cmp++; if (st !== {27'b0, irq_m, 1'b0, e.valid, 2'b10}) begin n_bad++; $display("FAIL basic_status: got %h want %h", st, {27'b0, irq_m, 1'b0, e.valid, 2'b10}); end
    n_cmp++; if (cnt !== 32'(opcnt_m)) begin n_bad++; $display("FAIL basic_opcnt: got %h want %h", cnt, opcnt_m); end
    n_cmp++; if (gpio_out !== 32'd1) begin n_bad++; $display("FAIL basic_gpio_out: got %h want 1", gpio_out); end
    irq_m = 1'b0;
    n_cmp++; if (irq !== irq_m) begin n_bad++; $display("FAIL basic_irq_clr: got %b want 0", irq); end
    bus_write(8'h40, 32'hFFFF_FFFF, 1);
    bus_read(8'h40, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", d); end
    bus_read(8'h00, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL arg1_readback: got %h want 3", d); end
    prev_prod = e.prod;
  endtask

  task automatic test_max();
    launch(32'h00FF_FFFF, 32'h00FF_FFFF, 1);
    wait_done(1, lat);
    n_cmp++; if (lat !== ARG_W + 3) begin n_bad++; $display("FAIL max_latency: got %0d want %0d", lat, ARG_W + 3); end
    pop_exp();
    read_results(lo, hi, on, st, cnt);
    n_cmp++; if ({hi, lo} !== e.prod) begin n_bad++; $display("FAIL max_product: got %h want %h", {hi, lo}, e.prod); end
    n_cmp++; if (on !== e.ones) begin n_bad++; $display("FAIL max_ones: got %0d want %0d", on, e.ones); end
    n_cmp++; if (st !== {27'b0, irq_m, 1'b0, e.valid, 2'b10}) begin n_bad++; $display("FAIL max_status: got %h want %h", st, {27'b0, irq_m, 1'b0, e.valid, 2'b10}); end
    n_cmp++; if (cnt !== 32'(opcnt_m)) begin n_bad++; $display("FAIL max_opcnt: got %h want %h", cnt, opcnt_m); end
    irq_m = 1'b0;
    prev_prod = e.prod;
  endtask

  task automatic test_busy_start();
    launch(32'h123, 32'h456, 1);
    repeat (2) @(negedge clk);
    bus_write(8'h10, 32'd1, 1);
    bus_write(8'h00, 32'd7, 1);
    bus_read(8'h18, d);
    n_cmp++; if (d !== prev_prod[31:0]) begin n_bad++; $display("FAIL busy_old_reslo: got %h want %h", d, prev_prod[31:0]); end
    bus_read(8'h00, d);
    n_cmp++; if (d !== 32'd7) begin n_bad++; $display("FAIL busy_arg1_write: got %h want 7", d); end
    wait_done(0, lat);
    pop_exp();
    read_results(lo, hi, on, st, cnt);
    n_cmp++; if ({hi, lo} !== e.prod) begin n_bad++; $display("FAIL busy_product: got %h want %h", {hi, lo}, e.prod); end
    n_cmp++; if (on !== e.ones) begin n_bad++; $display("FAIL busy_ones: got %0d want %0d", on, e.ones); end
    n_cmp++; if (st !== {27'b0, irq_m, 1'b1, e.valid, 2'b10}) begin n_bad++; $display("FAIL busy_status_err: got %h want %h", st, {27'b0, irq_m, 1'b1, e.valid, 2'b10}); end
    n_cmp++; if (cnt !== 32'(opcnt_m)) begin n_bad++; $display("FAIL busy_opcnt: got %h want %h", cnt, opcnt_m); end
    irq_m = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] offs [8];
    offs = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38};
    @(negedge clk); gpio_in = 32'hDEAD_BEEF; gpio_latch = 1'b1;
    @(negedge clk); gpio_latch = 1'b0;
    bus_read(8'h00, d);
    launch(32'd2, 32'd3, 1);
    repeat (9) @(negedge clk);
    n_reset = 1'b0; #1;
    sb.delete(); opcnt_m = '0; irq_m = 1'b0;
    n_cmp++; if (sdata_out !== 32'd0) begin n_bad++; $display("FAIL mrst_sdata_out: got %h want 0", sdata_out); end
    n_cmp++; if (gpio_out !== 32'd0) begin n_bad++; $display("FAIL mrst_gpio_out: got %h want 0", gpio_out); end
    n_cmp++; if (gpio_in_s_insp !== 32'd0) begin n_bad++; $display("FAIL mrst_insp: got %h want 0", gpio_in_s_insp); end
    @(negedge clk); n_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(offs[i], d);
      n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL mrst_reg_%0h: got %h want 0", offs[i], d); end
    end
    launch(32'd6, 32'd7, 1);
    wait_done(1, lat);
    n_cmp++; if (lat !== ARG_W + 3) begin n_bad++; $display("FAIL mrst_latency: got %0d want %0d", lat, ARG_W + 3); end
    pop_exp();
    read_results(lo, hi, on, st, cnt);
    n_cmp++; if ({hi, lo} !== e.prod) begin n_bad++; $display("FAIL mrst_product: got %h want %h", {hi, lo}, e.prod); end
    n_cmp++; if (st !== {27'b0, irq_m, 1'b0, e.valid, 2'b10}) begin n_bad++; $display("FAIL mrst_status: got %h want %h", st, {27'b0, irq_m, 1'b0, e.valid, 2'b10}); end
    n_cmp++; if (cnt !== 32'(opcnt_m)) begin n_bad++; $display("FAIL mrst_opcnt: got %h want %h", cnt, opcnt_m); end
    irq_m = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.opcnt = 16'hFFFF;
    @(negedge clk);
    release dut.opcnt;
    opcnt_m = 16'hFFFF;
    #1;
    n_cmp++; if (gpio_out !== 32'h0000_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want 0000ffff", gpio_out); end
    launch(32'd9, 32'd9, 1);
    wait_done(1, lat);
    pop_exp();
    n_cmp++; if (gpio_out !== 32'd0) begin n_bad++; $display("FAIL wrap_gpio_out: got %h want 0", gpio_out); end
    read_results(lo, hi, on, st, cnt);
    n_cmp++; if ({hi, lo} !== e.prod) begin n_bad++; $display("FAIL wrap_product: got %h want %h", {hi, lo}, e.prod); end
    n_cmp++; if (on !== e.ones) begin n_bad++; $display("FAIL wrap_ones: got %0d want %0d", on, e.ones); end
    n_cmp++; if (cnt !== 32'(opcnt_m)) begin n_bad++; $display("FAIL wrap_opcnt: got %h want %h", cnt, opcnt_m); end
    irq_m = 1'b0;
  endtask

  task automatic test_gpio_latch();
    @(negedge clk); gpio_in = 32'hA5A5_A5A5; gpio_latch = 1'b1;
    @(negedge clk); gpio_latch = 1'b0; gpio_in = 32'h1234_5678;
    @(negedge clk);
    n_cmp++; if (gpio_in_s_insp !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL latch_capture: got %h want a5a5a5a5", gpio_in_s_insp); end
    bus_read(8'h38, d);
    n_cmp++; if (d !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL latch_gpin_read: got %h want a5a5a5a5", d); end
    repeat (3) @(negedge clk);
    n_cmp++; if (gpio_in_s_insp !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL latch_hold: got %h want a5a5a5a5", gpio_in_s_insp); end
    gpio_latch = 1'b1;
    @(negedge clk); gpio_in = 32'h0F0F_0F0F;
    @(negedge clk); gpio_latch = 1'b0;
    n_cmp++; if (gpio_in_s_insp !== 32'h0F0F_0F0F) begin n_bad++; $display("FAIL latch_follow: got %h want 0f0f0f0f", gpio_in_s_insp); end
    n_cmp++; if (irq !== irq_m) begin n_bad++; $display("FAIL final_irq: got %b want %b", irq, irq_m); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_busy_start();
    test_mid_reset();
    test_wrap();
    test_gpio_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
